tile_map_blitter: RTL and testbench
===================================

// Module: tile_map_blitter
// PURPOSE
//  Bus initiator that fills a rectangle of the 40x30 tile map with a single tile code.
//  It issues one iomem write per tile into the map region (addr[23:20]=4'h2) of the HDMI tile/charset responder.
//  The CPU posts one command instead of up to 1200 individual stores.
//  Sits between the CPU command register and the shared iomem bus, in the clk domain.
// PARAMETERS
//  MAP_COLS  40            tiles per map row (1280/32)
//  MAP_ROWS  30            tile rows (720/24)
//  MAP_BASE  32'h0020_0000 byte address of map entry 0; bits[23:20]=4'h2
//  TIMEOUT   255           max cycles to wait for iomem_ready before abort
// PORTS
//  clk          in   1   system clock (100MHz)
//  reset        in   1   synchronous, active-high
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   high only in IDLE; command accepted when cmd_valid&&cmd_ready
//  cmd_x        in   6   start column
//  cmd_y        in   5   start row
//  cmd_w        in   6   width in tiles
//  cmd_h        in   5   height in tiles
//  cmd_tile     in   4   tile code to write
//  iomem_valid  out  1   write request
//  iomem_addr   out  32  byte address = MAP_BASE + 4*(row*MAP_COLS+col)
//  iomem_wdata  out  32  {28'h0, tile}
//  iomem_wstrb  out  4   4'hF while iomem_valid, else 4'h0
//  iomem_ready  in   1   responder completion pulse
//  busy         out  1   high from acceptance until done
//  done         out  1   one-cycle pulse at command end
//  err          out  1   sticky; set on reject/timeout, cleared on next acceptance
// BEHAVIOUR
//  Reset values: iomem_valid/busy/done/err=0, wstrb=0, addr/wdata=0, cmd_ready=1, state=IDLE.
//  Clock and reset: clock clk; reset is synchronous, active-high.
//  FSM IDLE->CHECK->ISSUE->GAP->(ISSUE|DONE)->IDLE; DONE lasts 1 cycle.
//  IDLE: on accept, register all cmd fields, set busy, clear err, go CHECK.
//  CHECK: reject if x>=MAP_COLS or y>=MAP_ROWS.
//   - On reject: err=1, go DONE, no bus write.
//   - Otherwise clip: ew=min(w,MAP_COLS-x), eh=min(h,MAP_ROWS-y).
//   - If ew==0 or eh==0: go DONE, no write, err stays 0.
//   - Otherwise load the row base y*MAP_COLS (shift-add, no multiplier), set col=0, go ISSUE.
//  ISSUE: drive iomem_valid=1 with addr/wdata/wstrb; these are stable while valid.
//   - On iomem_ready: drop valid next cycle and go GAP.
//   - Timeout counter reaches TIMEOUT with no ready: drop valid, err=1, go DONE; remaining tiles are skipped.
//  GAP: valid held low for exactly 1 cycle. This stops a registered responder from seeing a stale request.
//   - Advance col; when col==ew-1, set col=0, row_base+=MAP_COLS, row++.
//   - When the last tile (ew*eh) has been written, go DONE; else go ISSUE.
//  Order: row-major, left to right, top to bottom.
//  Per-tile cost with a 1-cycle-latency responder: 3 cycles (ISSUE, ready, GAP).
//  iomem_ready outside ISSUE is ignored.
//  A cmd_valid during busy is not accepted; it is held by the sender.
//  DONE: done=1 for one cycle, busy=0 next cycle, cmd_ready=1 next cycle.
//  Reset mid-operation: valid low on the next edge, and the in-flight write is abandoned.
//   - Responder-side completion of that write is harmless.
//  Arithmetic:
//   - index is 11 bits (max 1199); addr = MAP_BASE + {index,2'b00}.
//   - The min() compares are done at 7 bits to avoid wrap.
// STRUCTURE
//  hdmi_pkg gains:
//   - MAP_COLS_C, MAP_ROWS_C
//   - region codes REG_CHAR=4'h1, REG_MAP=4'h2
//   - typedef enum logic[2:0] blit_state_t {IDLE,CHECK,ISSUE,GAP,DONE}
//   - typedef map_idx_t = logic[10:0]
//  Single flat module; no sub-module warranted.
// TESTING
//  Responder model: ready pulses 1 cycle after valid; a programmable-delay variant is used for timeout tests.
//  1) cmd x=0,y=0,w=1,h=1,tile=5:
//     - expect one write, addr=0x0020_0000, wdata=5, wstrb=F
//     - done 3 cycles after CHECK, err=0
//  2) cmd x=38,y=28,w=4,h=4,tile=A:
//     - clipped to 2x2
//     - addrs MAP_BASE+4*{1158,1159,1198,1199} in order; err=0
//  3) cmd x=40,y=0 -> zero writes, done pulse, err=1; next valid cmd clears err.
//  4) cmd w=0 -> zero writes, done, err=0; cmd_valid during busy is not accepted until done.
//  5) Responder silent:
//     - valid drops after TIMEOUT=255 cycles, err=1, done
//     - a fresh full-screen fill (0,0,40,30) then makes 1200 writes in 3600 cycles
//  6) Reset asserted mid-fill after the 7th write is issued:
//     - iomem_valid=0, cmd_ready=1 next cycle
//     - no further writes

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared map geometry, iomem region codes and tile-map blitter types.
package hdmi_pkg;
    localparam int MAP_COLS_C = 40;
    localparam int MAP_ROWS_C = 30;
    localparam logic [3:0] REG_CHAR = 4'h1;
    localparam logic [3:0] REG_MAP = 4'h2;
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, GAP, DONE} blit_state_t;
    typedef logic [10:0] map_idx_t;
endpackage

// File: rtl/tile_map_blitter.sv
// tile_map_blitter: fills a clipped rectangle of the tile map with one tile code,
// one iomem write per tile, row-major, with a one-cycle gap between writes.
module tile_map_blitter
    import hdmi_pkg::*;
#(
    parameter int MAP_COLS = MAP_COLS_C,
    parameter int MAP_ROWS = MAP_ROWS_C,
    parameter logic [31:0] MAP_BASE = 32'h0020_0000,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [5:0]  cmd_w,
    input  logic [4:0]  cmd_h,
    input  logic [3:0]  cmd_tile,
    output logic        iomem_valid,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    output logic [3:0]  iomem_wstrb,
    input  logic        iomem_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    blit_state_t state, nxt;
    logic [5:0] x_q, w_q, ew, col, ew_c;
    logic [4:0] y_q, h_q, eh, row, eh_c;
    logic [3:0] tile_q;
    logic [7:0] tcnt;
    map_idx_t   row_base, idx;
    logic [6:0] room_x, room_y;
    logic       reject, empty, last, expired;

    // Clip arithmetic is 7 bits wide so MAP_COLS - x cannot wrap
    assign room_x  = 7'(MAP_COLS) - {1'b0, x_q};
    assign room_y  = 7'(MAP_ROWS) - {2'b0, y_q};
    assign reject  = ({1'b0, x_q} >= 7'(MAP_COLS)) || ({2'b0, y_q} >= 7'(MAP_ROWS));
    assign ew_c    = ({1'b0, w_q} < room_x) ? w_q : room_x[5:0];
    assign eh_c    = ({2'b0, h_q} < room_y) ? h_q : room_y[4:0];
    assign empty   = (ew_c == 6'd0) || (eh_c == 5'd0);
    assign last    = (col == ew - 6'd1) && (row == eh - 5'd1);
    assign expired = !iomem_ready && (tcnt == 8'(TIMEOUT - 1));
    assign idx     = row_base + map_idx_t'(x_q) + map_idx_t'(col);

    assign cmd_ready   = state == IDLE;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign iomem_valid = state == ISSUE;
    assign iomem_addr  = iomem_valid ? MAP_BASE + {19'd0, idx, 2'b00} : 32'd0;
    assign iomem_wdata = iomem_valid ? {28'd0, tile_q} : 32'd0;
    assign iomem_wstrb = iomem_valid ? 4'hF : 4'h0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_valid ? CHECK : IDLE;
            CHECK:   nxt = (reject || empty) ? DONE : ISSUE;
            ISSUE:   nxt = iomem_ready ? GAP : (expired ? DONE : ISSUE);
            GAP:     nxt = last ? DONE : ISSUE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            err      <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            tile_q   <= '0;
            ew       <= '0;
            eh       <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            tcnt     <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (cmd_valid) begin
                    x_q    <= cmd_x;
                    y_q    <= cmd_y;
                    w_q    <= cmd_w;
                    h_q    <= cmd_h;
                    tile_q <= cmd_tile;
                    err    <= 1'b0;
                end
                CHECK: begin
                    err      <= reject;
                    ew       <= ew_c;
                    eh       <= eh_c;
                    col      <= '0;
                    row      <= '0;
                    tcnt     <= '0;
                    // y*40 as y*32 + y*8
                    row_base <= map_idx_t'({y_q, 5'b0}) + map_idx_t'({y_q, 3'b0});
                end
                ISSUE: begin
                    tcnt <= tcnt + 8'd1;
                    if (expired) err <= 1'b1;
                end
                GAP: begin
                    tcnt <= '0;
                    if (col == ew - 6'd1) begin
                        col      <= '0;
                        row      <= row + 5'd1;
                        row_base <= row_base + map_idx_t'(MAP_COLS);
                    end else begin
                        col <= col + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_map_blitter.sv
// tb_tile_map_blitter: directed scenarios against a 1-cycle responder, a silent
// responder for timeout, and a mid-fill reset.
module tb_tile_map_blitter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_x = '0;
    logic [4:0]  cmd_y = '0;
    logic [5:0]  cmd_w = '0;
    logic [4:0]  cmd_h = '0;
    logic [3:0]  cmd_tile = '0;
    logic        iomem_valid;
    logic [31:0] iomem_addr, iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic        iomem_ready = 1'b0;
    logic        busy, done, err;
    logic        silent = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    int          vcyc = 0;

    tile_map_blitter dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_tile(cmd_tile),
        .iomem_valid(iomem_valid), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_wstrb(iomem_wstrb), .iomem_ready(iomem_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Responder pulses ready one cycle after it sees valid; records completed writes
    always @(posedge clk) begin
        iomem_ready <= !silent && iomem_valid && !iomem_ready;
        if (iomem_valid) vcyc <= vcyc + 1;
        if (iomem_valid && iomem_ready) begin
            wa.push_back(iomem_addr);
            wd.push_back(iomem_wdata);
            ws.push_back(iomem_wstrb);
        end
    end

    function automatic logic [31:0] map_addr(input int idx);
        return 32'h0020_0000 + 32'(idx * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [5:0] x, input logic [4:0] y, input logic [5:0] w,
                            input logic [4:0] h, input logic [3:0] t);
        int n = 0;
        @(negedge clk);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_tile = t; cmd_valid = 1'b1;
        while (!cmd_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: cmd_ready never rose");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!done && cyc < 6000);
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout: no done pulse after %0d cycles", cyc);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); ws.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(iomem_valid), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", iomem_addr, 0);
        chk("rst_wdata", iomem_wdata, 0);
        chk("rst_wstrb", 32'(iomem_wstrb), 0);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        clear_log();
        send_cmd(6'd0, 5'd0, 6'd1, 5'd1, 4'h5);
        chk("single_busy", 32'(busy), 1);
        wait_done(cyc);
        chk("single_latency", 32'(cyc), 4);
        chk("single_count", 32'(wa.size()), 1);
        if (wa.size() == 1) begin
            chk("single_addr", wa[0], 32'h0020_0000);
            chk("single_wdata", wd[0], 32'd5);
            chk("single_wstrb", 32'(ws[0]), 32'hF);
        end
        chk("single_err", 32'(err), 0);
        @(posedge clk);
        #1 chk("single_idle_ready", 32'(cmd_ready), 1);
        chk("single_idle_busy", 32'(busy), 0);
    endtask

    task automatic test_clip();
        int cyc;
        int exp_idx[4] = '{1158, 1159, 1198, 1199};
        clear_log();
        send_cmd(6'd38, 5'd28, 6'd4, 5'd4, 4'hA);
        wait_done(cyc);
        chk("clip_latency", 32'(cyc), 13);
        chk("clip_count", 32'(wa.size()), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk($sformatf("clip_addr%0d", i), wa[i], map_addr(exp_idx[i]));
            chk($sformatf("clip_wdata%0d", i), wd[i], 32'hA);
        end
        chk("clip_err", 32'(err), 0);
    endtask

    task automatic test_reject();
        int cyc;
        clear_log();
        send_cmd(6'd40, 5'd0, 6'd3, 5'd3, 4'h1);
        wait_done(cyc);
        chk("rej_latency", 32'(cyc), 1);
        chk("rej_count", 32'(wa.size()), 0);
        chk("rej_err_at_done", 32'(err), 1);
        repeat (3) @(posedge clk);
        #1 chk("rej_err_sticky", 32'(err), 1);
        send_cmd(6'd0, 5'd29, 6'd0, 5'd1, 4'h1);
        chk("rej_err_cleared", 32'(err), 0);
        wait_done(cyc);
        chk("rej_row_bad_y", 32'(err), 0);
        send_cmd(6'd0, 5'd30, 6'd1, 5'd1, 4'h1);
        wait_done(cyc);
        chk("rej_y30_err", 32'(err), 1);
    endtask

    task automatic test_zero_and_busy_hold();
        int cyc;
        logic ready_seen = 1'b0;
        clear_log();
        send_cmd(6'd3, 5'd3, 6'd0, 5'd5, 4'h2);
        chk("zero_ready_busy", 32'(cmd_ready), 0);
        wait_done(cyc);
        chk("zero_latency", 32'(cyc), 1);
        chk("zero_count", 32'(wa.size()), 0);
        chk("zero_err", 32'(err), 0);
        send_cmd(6'd0, 5'd0, 6'd2, 5'd1, 4'h3);
        cmd_x = 6'd10; cmd_y = 5'd1; cmd_w = 6'd1; cmd_h = 5'd1; cmd_tile = 4'h7;
        cmd_valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
            if (cmd_ready) ready_seen = 1'b1;
        end while (!done && cyc < 100);
        chk("hold_not_accepted", 32'(ready_seen), 0);
        chk("hold_first_count", 32'(wa.size()), 2);
        @(posedge clk);
        #1 chk("hold_idle_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("hold_accepted", 32'(busy), 1);
        wait_done(cyc);
        chk("hold_second_count", 32'(wa.size()), 3);
        if (wa.size() == 3) chk("hold_second_addr", wa[2], map_addr(50));
    endtask

    task automatic test_timeout_and_full();
        int cyc, v0;
        clear_log();
        silent = 1'b1;
        v0 = vcyc;
        send_cmd(6'd0, 5'd0, 6'd1, 5'd1, 4'h4);
        wait_done(cyc);
        chk("to_latency", 32'(cyc), 256);
        chk("to_valid_cycles", 32'(vcyc - v0), 255);
        chk("to_valid_low", 32'(iomem_valid), 0);
        chk("to_err", 32'(err), 1);
        chk("to_count", 32'(wa.size()), 0);
        silent = 1'b0;
        @(posedge clk);
        send_cmd(6'd0, 5'd0, 6'd40, 5'd30, 4'h9);
        wait_done(cyc);
        chk("full_cycles", 32'(cyc), 3601);
        chk("full_count", 32'(wa.size()), 1200);
        if (wa.size() == 1200) begin
            chk("full_first", wa[0], map_addr(0));
            chk("full_row1", wa[40], map_addr(40));
            chk("full_last", wa[1199], map_addr(1199));
        end
        chk("full_err", 32'(err), 0);
    endtask

    task automatic test_reset_mid_fill();
        int n = 0;
        int v0;
        clear_log();
        send_cmd(6'd0, 5'd0, 6'd40, 5'd30, 4'h6);
        while (!(iomem_valid && wa.size() == 6) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("mid_7th_issued", 32'(iomem_valid && wa.size() == 6), 1);
        chk("mid_7th_addr", iomem_addr, map_addr(6));
        reset = 1'b1;
        @(posedge clk);
        #1 chk("mid_valid_low", 32'(iomem_valid), 0);
        chk("mid_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_busy", 32'(busy), 0);
        reset = 1'b0;
        v0 = vcyc;
        repeat (20) @(posedge clk);
        #1 chk("mid_no_more_valid", 32'(vcyc - v0), 0);
        chk("mid_still_idle", 32'(cmd_ready), 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_reject();
        test_zero_and_busy_hold();
        test_timeout_and_full();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
